// File: rtl/apb_rr_master_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : apb_rr_master_arbiter
//  Purpose  : Round-robin sharing of one APB3 master port between NREQ
//             requesters, with PCLKEN-qualified phases and a PREADY timeout.
//  Revision : 1.0 - initial release
// ============================================================================
module apb_rr_master_arbiter #(
    parameter int NREQ      = 2,
    parameter int ADDRWIDTH = 16,
    parameter int DATAWIDTH = 32,
    parameter int TIMEOUT   = 255
) (
    input  logic                      HCLK,
    input  logic                      HRESET,
    input  logic [NREQ-1:0]           REQ_VALID,
    output logic [NREQ-1:0]           REQ_READY,
    input  logic [NREQ-1:0]           REQ_WRITE,
    input  logic [NREQ*ADDRWIDTH-1:0] REQ_ADDR,
    input  logic [NREQ*DATAWIDTH-1:0] REQ_WDATA,
    output logic [NREQ-1:0]           RSP_VALID,
    output logic [DATAWIDTH-1:0]      RSP_RDATA,
    output logic                      RSP_ERR,
    output logic                      TIMEOUT_EV,
    input  logic                      PCLKEN,
    output logic                      PSEL,
    output logic                      PENABLE,
    output logic                      PWRITE,
    output logic [ADDRWIDTH-1:0]      PADDR,
    output logic [DATAWIDTH-1:0]      PWDATA,
    input  logic [DATAWIDTH-1:0]      PRDATA,
    input  logic                      PREADY,
    input  logic                      PSLVERR
);

    localparam int c_PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int c_SUM_W = c_PTR_W + 1;
    localparam int c_CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam bit c_TMO_EN = (TIMEOUT != 0);
    localparam logic [c_CNT_W-1:0] c_TMO_LAST =
        (TIMEOUT == 0) ? '0 : c_CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_SETUP  = 2'b10,
        S_ACCESS = 2'b11
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [c_PTR_W-1:0]     r_ptr;
    logic [c_PTR_W-1:0]     r_owner;
    logic [c_CNT_W-1:0]     r_cnt;
    logic                   r_pwrite;
    logic [ADDRWIDTH-1:0]   r_paddr;
    logic [DATAWIDTH-1:0]   r_pwdata;
    logic [NREQ-1:0]        r_rsp_valid;
    logic [DATAWIDTH-1:0]   r_rsp_rdata;
    logic                   r_rsp_err;
    logic                   r_tmo_ev;

    logic [c_PTR_W-1:0]     w_winner;
    logic                   w_found;
    logic [NREQ-1:0]        w_grant;
    logic                   w_accept;
    logic [c_PTR_W-1:0]     w_ptr_nxt;
    logic                   w_tmo_hit;
    logic                   w_done;
    logic                   w_timeout;
    logic [NREQ-1:0]        w_owner_oh;

    // Scan from the highest offset down so the lowest offset from r_ptr wins.
    always_comb begin : p_pick
        logic [c_SUM_W-1:0] sum;
        logic [c_PTR_W-1:0] idx;
        sum      = '0;
        idx      = '0;
        w_winner = '0;
        w_found  = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            sum = {1'b0, r_ptr} + c_SUM_W'(k);
            if (sum >= c_SUM_W'(NREQ)) begin
                sum = sum - c_SUM_W'(NREQ);
            end
            idx = sum[c_PTR_W-1:0];
            if (REQ_VALID[idx]) begin
                w_winner = idx;
                w_found  = 1'b1;
            end
        end
    end

    always_comb begin
        w_grant = '0;
        if ((r_state == S_IDLE) && w_found && !HRESET) begin
            w_grant[w_winner] = 1'b1;
        end
    end

    assign REQ_READY = w_grant;
    assign w_accept  = |w_grant;
    assign w_ptr_nxt = (w_winner == c_PTR_W'(NREQ - 1)) ? '0 : w_winner + c_PTR_W'(1);

    assign w_tmo_hit  = c_TMO_EN && (r_cnt == c_TMO_LAST);
    assign w_done     = (r_state == S_ACCESS) && PCLKEN && PREADY;
    assign w_timeout  = (r_state == S_ACCESS) && PCLKEN && !PREADY && w_tmo_hit;
    assign w_owner_oh = {{(NREQ-1){1'b0}}, 1'b1} << r_owner;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_accept)              w_state_nxt = S_SETUP;
            S_SETUP:  if (PCLKEN)                w_state_nxt = S_ACCESS;
            S_ACCESS: if (w_done || w_timeout)   w_state_nxt = S_IDLE;
            default:                             w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_ptr       <= '0;
            r_owner     <= '0;
            r_cnt       <= '0;
            r_pwrite    <= 1'b0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
            r_rsp_valid <= '0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_tmo_ev    <= 1'b0;
        end else begin
            r_rsp_valid <= '0;
            r_rsp_err   <= 1'b0;
            r_tmo_ev    <= 1'b0;

            if (w_accept) begin
                r_paddr  <= REQ_ADDR[int'(w_winner) * ADDRWIDTH +: ADDRWIDTH];
                r_pwdata <= REQ_WDATA[int'(w_winner) * DATAWIDTH +: DATAWIDTH];
                r_pwrite <= REQ_WRITE[w_winner];
                r_owner  <= w_winner;
                r_ptr    <= w_ptr_nxt;
            end

            if ((r_state == S_SETUP) && PCLKEN) begin
                r_cnt <= '0;
            end else if ((r_state == S_ACCESS) && PCLKEN && !PREADY && !w_tmo_hit) begin
                r_cnt <= r_cnt + c_CNT_W'(1);
            end

            // A ready slave on the final wait cycle completes normally, not as a timeout.
            if (w_done) begin
                r_rsp_valid <= w_owner_oh;
                r_rsp_rdata <= PRDATA;
                r_rsp_err   <= PSLVERR;
            end else if (w_timeout) begin
                r_rsp_valid <= w_owner_oh;
                r_rsp_rdata <= '0;
                r_rsp_err   <= 1'b1;
                r_tmo_ev    <= 1'b1;
            end
        end
    end

    assign PSEL       = (r_state != S_IDLE);
    assign PENABLE    = (r_state == S_ACCESS);
    assign PWRITE     = r_pwrite;
    assign PADDR      = r_paddr;
    assign PWDATA     = r_pwdata;
    assign RSP_VALID  = r_rsp_valid;
    assign RSP_RDATA  = r_rsp_rdata;
    assign RSP_ERR    = r_rsp_err;
    assign TIMEOUT_EV = r_tmo_ev;

endmodule
`default_nettype wire

// File: tb/tb_apb_rr_master_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_apb_rr_master_arbiter
//  Purpose  : Directed vector table plus hand-written multi-cycle sequences.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_apb_rr_master_arbiter;

    localparam int NREQ = 2;
    localparam int AW   = 16;
    localparam int DW   = 32;
    localparam int TMO  = 4;

    logic              hclk = 1'b0;
    logic              hreset;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   req_write;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_wdata;
    logic [NREQ-1:0]   rsp_valid;
    logic [DW-1:0]     rsp_rdata;
    logic              rsp_err;
    logic              timeout_ev;
    logic              pclken;
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [AW-1:0]     paddr;
    logic [DW-1:0]     pwdata;
    logic [DW-1:0]     prdata;
    logic              pready;
    logic              pslverr;

    int errors = 0;
    int checks = 0;

    always #5 hclk = ~hclk;

    apb_rr_master_arbiter #(
        .NREQ      (NREQ),
        .ADDRWIDTH (AW),
        .DATAWIDTH (DW),
        .TIMEOUT   (TMO)
    ) dut (
        .HCLK       (hclk),
        .HRESET     (hreset),
        .REQ_VALID  (req_valid),
        .REQ_READY  (req_ready),
        .REQ_WRITE  (req_write),
        .REQ_ADDR   (req_addr),
        .REQ_WDATA  (req_wdata),
        .RSP_VALID  (rsp_valid),
        .RSP_RDATA  (rsp_rdata),
        .RSP_ERR    (rsp_err),
        .TIMEOUT_EV (timeout_ev),
        .PCLKEN     (pclken),
        .PSEL       (psel),
        .PENABLE    (penable),
        .PWRITE     (pwrite),
        .PADDR      (paddr),
        .PWDATA     (pwdata),
        .PRDATA     (prdata),
        .PREADY     (pready),
        .PSLVERR    (pslverr)
    );

    typedef struct {
        logic        rst;
        logic [1:0]  vld;
        logic        prdy;
        logic [31:0] prd;
        logic [1:0]  rdy;
        logic        ps;
        logic        pe;
        logic [1:0]  rv;
        logic        err;
        logic        ca;
        logic [15:0] ad;
        logic        cr;
        logic [31:0] rd;
    } vec_t;

    localparam int NV = 26;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic rst, input logic [1:0] vld, input logic prdy,
                                input logic [31:0] prd, input logic [1:0] rdy, input logic ps,
                                input logic pe, input logic [1:0] rv, input logic err,
                                input logic ca, input logic [15:0] ad, input logic cr,
                                input logic [31:0] rd);
        vec_t v;
        v.rst = rst; v.vld = vld; v.prdy = prdy; v.prd = prd; v.rdy = rdy;
        v.ps = ps; v.pe = pe; v.rv = rv; v.err = err;
        v.ca = ca; v.ad = ad; v.cr = cr; v.rd = rd;
        return v;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick_in();
        @(negedge hclk);
    endtask

    initial begin
        // rst, vld, prdy, prdata | ready, psel, penable, rsp_valid, err | chk addr | chk rdata
        vecs[0]  = mk(1, 2'b11, 0, 32'h0,        2'b00, 0, 0, 2'b00, 0, 1, 16'h0000, 1, 32'h0);
        vecs[1]  = mk(0, 2'b10, 1, 32'hDEADBEEF, 2'b10, 0, 0, 2'b00, 0, 0, 16'h0000, 0, 32'h0);
        vecs[2]  = mk(0, 2'b00, 1, 32'hDEADBEEF, 2'b00, 1, 0, 2'b00, 0, 1, 16'h0040, 0, 32'h0);
        vecs[3]  = mk(0, 2'b00, 1, 32'hDEADBEEF, 2'b00, 1, 1, 2'b00, 0, 1, 16'h0040, 0, 32'h0);
        vecs[4]  = mk(0, 2'b00, 1, 32'h0,        2'b00, 0, 0, 2'b10, 0, 0, 16'h0000, 1, 32'hDEADBEEF);
        vecs[5]  = mk(0, 2'b11, 1, 32'h0,        2'b01, 0, 0, 2'b00, 0, 0, 16'h0000, 1, 32'hDEADBEEF);
        vecs[6]  = mk(0, 2'b11, 1, 32'h0,        2'b00, 1, 0, 2'b00, 0, 1, 16'h0010, 0, 32'h0);
        vecs[7]  = mk(0, 2'b11, 1, 32'h10,       2'b00, 1, 1, 2'b00, 0, 1, 16'h0010, 0, 32'h0);
        vecs[8]  = mk(0, 2'b11, 1, 32'h0,        2'b10, 0, 0, 2'b01, 0, 0, 16'h0000, 1, 32'h10);
        vecs[9]  = mk(0, 2'b11, 1, 32'h0,        2'b00, 1, 0, 2'b00, 0, 1, 16'h0040, 0, 32'h0);
        vecs[10] = mk(0, 2'b11, 1, 32'h40,       2'b00, 1, 1, 2'b00, 0, 1, 16'h0040, 0, 32'h0);
        vecs[11] = mk(0, 2'b11, 1, 32'h0,        2'b01, 0, 0, 2'b10, 0, 0, 16'h0000, 1, 32'h40);
        vecs[12] = mk(0, 2'b11, 1, 32'h0,        2'b00, 1, 0, 2'b00, 0, 1, 16'h0010, 0, 32'h0);
        vecs[13] = mk(0, 2'b11, 1, 32'h11,       2'b00, 1, 1, 2'b00, 0, 1, 16'h0010, 0, 32'h0);
        vecs[14] = mk(0, 2'b11, 1, 32'h0,        2'b10, 0, 0, 2'b01, 0, 0, 16'h0000, 1, 32'h11);
        vecs[15] = mk(0, 2'b00, 1, 32'h0,        2'b00, 1, 0, 2'b00, 0, 1, 16'h0040, 0, 32'h0);
        vecs[16] = mk(0, 2'b00, 1, 32'h41,       2'b00, 1, 1, 2'b00, 0, 1, 16'h0040, 0, 32'h0);
        vecs[17] = mk(0, 2'b00, 1, 32'h0,        2'b00, 0, 0, 2'b10, 0, 0, 16'h0000, 1, 32'h41);
        vecs[18] = mk(0, 2'b01, 0, 32'h0,        2'b01, 0, 0, 2'b00, 0, 0, 16'h0000, 0, 32'h0);
        vecs[19] = mk(0, 2'b00, 0, 32'h0,        2'b00, 1, 0, 2'b00, 0, 1, 16'h0010, 0, 32'h0);
        vecs[20] = mk(0, 2'b00, 0, 32'h0,        2'b00, 1, 1, 2'b00, 0, 1, 16'h0010, 0, 32'h0);
        vecs[21] = mk(1, 2'b00, 0, 32'h0,        2'b00, 1, 1, 2'b00, 0, 1, 16'h0010, 0, 32'h0);
        vecs[22] = mk(0, 2'b11, 0, 32'h0,        2'b01, 0, 0, 2'b00, 0, 1, 16'h0000, 1, 32'h0);
        vecs[23] = mk(0, 2'b00, 1, 32'h0,        2'b00, 1, 0, 2'b00, 0, 1, 16'h0010, 0, 32'h0);
        vecs[24] = mk(0, 2'b00, 1, 32'hCAFE0001, 2'b00, 1, 1, 2'b00, 0, 1, 16'h0010, 0, 32'h0);
        vecs[25] = mk(0, 2'b00, 1, 32'h0,        2'b00, 0, 0, 2'b01, 0, 0, 16'h0000, 1, 32'hCAFE0001);

        hreset    = 1'b1;
        req_valid = '0;
        req_write = '0;
        req_addr  = {16'h0040, 16'h0010};
        req_wdata = {32'hB1B11111, 32'hA0A00000};
        pclken    = 1'b1;
        pready    = 1'b0;
        pslverr   = 1'b0;
        prdata    = '0;
        repeat (2) @(posedge hclk);

        for (int i = 0; i < NV; i++) begin
            tick_in();
            hreset    = vecs[i].rst;
            req_valid = vecs[i].vld;
            pready    = vecs[i].prdy;
            prdata    = vecs[i].prd;
            #1;
            check($sformatf("vec%0d ctl", i),
                  {req_ready, psel, penable, rsp_valid, rsp_err, timeout_ev},
                  {vecs[i].rdy, vecs[i].ps, vecs[i].pe, vecs[i].rv, vecs[i].err, 1'b0});
            if (vecs[i].ca) check($sformatf("vec%0d paddr", i), paddr, vecs[i].ad);
            if (vecs[i].cr) check($sformatf("vec%0d rdata", i), rsp_rdata, vecs[i].rd);
        end

        // PCLKEN every 4th HCLK: write from req0, SETUP and ACCESS stretch to 4 cycles.
        req_write[0]     = 1'b1;
        req_addr[15:0]   = 16'h0008;
        req_wdata[31:0]  = 32'h12345678;
        tick_in();
        req_valid = 2'b01;
        pclken    = 1'b0;
        pready    = 1'b1;
        #1;
        check("slow accept", req_ready, 2'b01);
        for (int i = 0; i < 8; i++) begin
            tick_in();
            req_valid = 2'b00;
            pclken    = ((i % 4) == 3);
            #1;
            check($sformatf("slow cyc%0d", i),
                  {psel, penable, pwrite, paddr, pwdata, rsp_valid},
                  {1'b1, (i >= 4), 1'b1, 16'h0008, 32'h12345678, 2'b00});
        end
        tick_in();
        pclken = 1'b1;
        #1;
        check("slow rsp", {rsp_valid, rsp_err, psel}, {2'b01, 1'b0, 1'b0});

        // Three wait states then PSLVERR: completes on the last permissible cycle.
        tick_in();
        req_valid = 2'b10;
        pready    = 1'b0;
        #1;
        check("err accept", req_ready, 2'b10);
        tick_in();
        req_valid = 2'b00;
        #1;
        check("err setup", {psel, penable}, 2'b10);
        for (int i = 0; i < 4; i++) begin
            tick_in();
            pready  = (i == 3);
            pslverr = (i == 3);
            prdata  = 32'h5555AAAA;
            #1;
            check($sformatf("err access%0d", i), {psel, penable, timeout_ev}, 3'b110);
        end
        tick_in();
        pready  = 1'b0;
        pslverr = 1'b0;
        #1;
        check("err rsp", {rsp_valid, rsp_err, timeout_ev, psel}, {2'b10, 1'b1, 1'b0, 1'b0});
        check("err rdata", rsp_rdata, 32'h5555AAAA);
        tick_in();
        #1;
        check("err pulse", {rsp_valid, rsp_err}, 3'b000);

        // Stuck PREADY: timeout after 4 ACCESS cycles, then req1 gets the bus.
        tick_in();
        req_valid = 2'b11;
        prdata    = 32'hFFFFFFFF;
        #1;
        check("tmo accept", req_ready, 2'b01);
        tick_in();
        req_valid = 2'b10;
        #1;
        check("tmo setup", {psel, penable, paddr}, {2'b10, 16'h0008});
        for (int i = 0; i < 4; i++) begin
            tick_in();
            #1;
            check($sformatf("tmo access%0d", i), {psel, penable, timeout_ev, rsp_valid}, 5'b11000);
        end
        tick_in();
        req_valid = 2'b11;
        #1;
        check("tmo rsp", {rsp_valid, rsp_err, timeout_ev, psel}, {2'b01, 1'b1, 1'b1, 1'b0});
        check("tmo rdata", rsp_rdata, 32'h0);
        check("tmo next grant", req_ready, 2'b10);
        tick_in();
        req_valid = 2'b00;
        #1;
        check("tmo req1 setup", {psel, penable, rsp_valid, rsp_err, timeout_ev, paddr},
              {2'b10, 2'b00, 1'b0, 1'b0, 16'h0040});
        tick_in();
        pready = 1'b1;
        prdata = 32'h600D600D;
        #1;
        check("tmo req1 access", {psel, penable}, 2'b11);
        tick_in();
        pready = 1'b0;
        #1;
        check("tmo req1 rsp", {rsp_valid, rsp_err, timeout_ev, rsp_rdata},
              {2'b10, 1'b0, 1'b0, 32'h600D600D});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
